// File: rtl/apb_master_pkg.sv
// Shared types for the APB requester: FSM state encoding, response record and timer sizing.
package apb_master_pkg;

    localparam int unsigned APB_DATA_WIDTH = 32;
    localparam int unsigned APB_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_mst_state_e;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      error;
        logic                      timeout;
    } apb_rsp_t;

    // A zero-cycle timeout still needs a 1-bit counter to keep the vector legal.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait counter; flags the enabled step that reaches the limit.
module apb_wait_timer
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = timer_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Asserted on the wait cycle whose increment would make the count equal the limit.
    assign expired = (TIMEOUT_CYCLES != 0) && en && (count_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: one valid/ready command in, one SETUP+ACCESS transfer, one response out.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_mst_state_e state_q;
    apb_rsp_t       rsp_q;
    logic           timer_en;
    logic           timer_clr;
    logic           timer_expired;

    assign timer_en  = (state_q == ACCESS) && !PREADY;
    assign timer_clr = (state_q != ACCESS);

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            cmd_ready <= 1'b1;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        PSELx     <= 1'b1;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    // PREADY takes priority over a timeout expiring on the same edge.
                    if (PREADY) begin
                        rsp_q <= '{rdata:   PWRITE ? '0 : APB_DATA_WIDTH'(PRDATA),
                                   error:   PSLVERR,
                                   timeout: 1'b0};
                    end else if (timer_expired) begin
                        rsp_q <= '{rdata: '0, error: 1'b1, timeout: 1'b1};
                    end
                    if (PREADY || timer_expired) begin
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
            endcase
        end
    end

    assign rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
    assign rsp_error   = rsp_q.error;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge with a transaction-timeline reference model.
module tb_apb_master_bridge;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int TO = 16;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          waits;
        bit          err;
    } plan_t;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;
    logic          PSELx;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    apb_master_bridge #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .PSELx       (PSELx),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    acc_cnt = 0;
    int    done_cnt = 0;
    int    aborted = 0;
    int    rdy_force = 0;
    plan_t q[$];
    plan_t cur;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    always @(posedge PCLK) cyc++;

    // Completer: PREADY rises on ACCESS cycle number `waits`; bus inputs are noise elsewhere.
    int acnt = 0;
    always @(posedge PCLK) begin
        #1;
        if (PSELx && PENABLE) begin
            PREADY  = (acnt == cur.waits);
            PRDATA  = PREADY ? cur.rd : $urandom;
            PSLVERR = PREADY ? cur.err : 1'($urandom);
            acnt++;
        end else begin
            acnt    = 0;
            PREADY  = 1'($urandom);
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
        end
    end

    always @(posedge PCLK) begin
        #1;
        if (rdy_force > 0) begin
            rsp_ready = 1'b0;
            rdy_force--;
        end else begin
            rsp_ready = ($urandom_range(0, 9) < 6);
        end
    end

    // Reference model: each accepted command owns a timeline of SETUP, `lat` ACCESS cycles,
    // then RESP until taken; lat = waits+1, or TO if the completer stalls too long.
    bit          busy = 0;
    int          acc_edge = 0;
    int          lat = 0;
    int          rel;
    bit          exp_to;
    logic        last_wr = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wd = '0;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            busy      = 0;
            last_wr   = 1'b0;
            last_addr = '0;
            last_wd   = '0;
            check("rst_cmd_ready", cmd_ready, 1);
            check("rst_psel", PSELx, 0);
            check("rst_penable", PENABLE, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_paddr", PADDR, 0);
        end else begin
            check("paddr", PADDR, last_addr);
            check("pwrite", PWRITE, last_wr);
            check("pwdata", PWDATA, last_wd);
            if (!busy) begin
                check("idle_cmd_ready", cmd_ready, 1);
                check("idle_psel", PSELx, 0);
                check("idle_penable", PENABLE, 0);
                check("idle_rsp_valid", rsp_valid, 0);
                if (cmd_valid) begin
                    if (q.size() == 0) begin
                        fail_now("accept_without_plan");
                    end else begin
                        cur       = q.pop_front();
                        busy      = 1;
                        acc_edge  = cyc + 1;
                        lat       = (cur.waits < TO) ? cur.waits + 1 : TO;
                        last_wr   = cur.wr;
                        last_addr = cur.addr;
                        last_wd   = cur.wdata;
                        acc_cnt++;
                    end
                end
            end else begin
                rel = cyc - acc_edge;
                check("busy_cmd_ready", cmd_ready, 0);
                check("psel", PSELx, (rel <= lat) ? 1 : 0);
                check("penable", PENABLE, (rel >= 1 && rel <= lat) ? 1 : 0);
                check("rsp_valid", rsp_valid, (rel > lat) ? 1 : 0);
                if (rel > lat) begin
                    exp_to = (cur.waits >= TO);
                    check("rsp_rdata", rsp_rdata, (exp_to || cur.wr) ? 0 : cur.rd);
                    check("rsp_error", rsp_error, (exp_to || cur.err) ? 1 : 0);
                    check("rsp_timeout", rsp_timeout, exp_to ? 1 : 0);
                    if (rsp_ready) begin
                        busy = 0;
                        done_cnt++;
                    end
                end
            end
        end
    end

    task automatic issue(input plan_t p);
        int n;
        int start;
        start = acc_cnt;
        q.push_back(p);
        cmd_write = p.wr;
        cmd_addr  = p.addr;
        cmd_wdata = p.wdata;
        cmd_valid = 1'b1;
        n = 0;
        while (acc_cnt == start && n < 300) begin
            @(posedge PCLK);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (acc_cnt == start) begin
            fail_now("accept_wait");
            q.delete();
        end
    endtask

    // Cycle 1 is SETUP right after the accepting edge; returns the cycle rsp_valid shows up.
    task automatic measure(output int cycles, output int pen);
        cycles = 1;
        pen    = 0;
        while (!rsp_valid && cycles < 100) begin
            @(posedge PCLK);
            #1;
            cycles++;
            if (PENABLE) pen++;
        end
        if (!rsp_valid) fail_now("rsp_wait");
    endtask

    function automatic plan_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rd, input int waits, input bit err);
        plan_t p;
        p.wr = wr; p.addr = addr; p.wdata = wd; p.rd = rd; p.waits = waits; p.err = err;
        return p;
    endfunction

    function automatic plan_t rnd_plan();
        int sel;
        int w;
        sel = int'($urandom_range(0, 19));
        if (sel < 14)      w = int'($urandom_range(0, 4));
        else if (sel < 17) w = int'($urandom_range(14, 16));
        else               w = int'($urandom_range(17, 20));
        return mk(1'($urandom), $urandom, $urandom, $urandom, w, 1'($urandom));
    endfunction

    int c;
    int pe;
    int n;

    initial begin
        cur = mk(1'b0, '0, '0, '0, 0, 1'b0);
        repeat (3) @(posedge PCLK);
        #2 PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        // Zero-wait write.
        issue(mk(1'b1, 32'h04, 32'hA5, 32'hDEAD, 0, 1'b0));
        measure(c, pe);
        check("t1_latency", c, 3);
        check("t1_penable_cycles", pe, 1);
        check("t1_pwdata", PWDATA, 32'hA5);
        check("t1_rdata", rsp_rdata, 0);
        check("t1_error", rsp_error, 0);

        // Read with three wait states.
        issue(mk(1'b0, 32'h08, 32'h0, 32'h5A, 3, 1'b0));
        measure(c, pe);
        check("t2_penable_cycles", pe, 4);
        check("t2_latency", c, 6);
        check("t2_rdata", rsp_rdata, 32'h5A);
        check("t2_error", rsp_error, 0);

        // Completer error, then a normal command.
        issue(mk(1'b0, 32'h0C, 32'h0, 32'h77, 1, 1'b1));
        measure(c, pe);
        check("t3_error", rsp_error, 1);
        check("t3_timeout", rsp_timeout, 0);
        issue(mk(1'b1, 32'h10, 32'h33, 32'h0, 0, 1'b0));
        measure(c, pe);
        check("t3_next_error", rsp_error, 0);

        // Completer never ready.
        issue(mk(1'b0, 32'h14, 32'h0, 32'h99, 1000, 1'b0));
        measure(c, pe);
        check("t4_latency", c, 18);
        check("t4_penable_cycles", pe, 16);
        check("t4_error", rsp_error, 1);
        check("t4_timeout", rsp_timeout, 1);
        check("t4_rdata", rsp_rdata, 0);
        check("t4_psel", PSELx, 0);

        // Held response with the next command waiting; PREADY on the would-expire cycle.
        rdy_force = 9;
        issue(mk(1'b0, 32'h18, 32'h1, 32'hC3, 0, 1'b0));
        issue(mk(1'b0, 32'h1C, 32'h2, 32'h3C, 15, 1'b0));
        measure(c, pe);
        check("t5_edge_latency", c, 18);
        check("t5_edge_timeout", rsp_timeout, 0);
        check("t5_edge_rdata", rsp_rdata, 32'h3C);

        // Reset during ACCESS.
        issue(mk(1'b0, 32'h20, 32'h0, 32'h11, 10, 1'b0));
        repeat (3) begin
            @(posedge PCLK);
            #1;
        end
        check("t6_in_access", PENABLE, 1);
        #1 PRESETn = 1'b0;
        #1;
        aborted++;
        check("t6_psel_async", PSELx, 0);
        check("t6_penable_async", PENABLE, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_cmd_ready", cmd_ready, 1);
        repeat (2) @(posedge PCLK);
        #2 PRESETn = 1'b1;
        @(posedge PCLK);
        #1;
        check("t6_ready_after", cmd_ready, 1);

        for (int i = 0; i < 80; i++) begin
            issue(rnd_plan());
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge PCLK);
                    #1;
                end
            end
        end

        n = 0;
        while (done_cnt + aborted != acc_cnt && n < 500) begin
            @(posedge PCLK);
            n++;
        end
        if (done_cnt + aborted != acc_cnt) fail_now("drain");
        repeat (2) @(posedge PCLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
